// File: rtl/req_grant_pkg.sv
// Shared types and defaults for the round-robin request/grant arbiter.
// Holds the FSM state encoding and the pointer wrap helper.
package req_grant_pkg;

    localparam int unsigned DEF_N_REQ    = 32'd4;
    localparam int unsigned DEF_MAX_HOLD = 32'd8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    // Increment an index and wrap it back to zero at the modulus.
    function automatic int unsigned wrap_inc(input int unsigned value, input int unsigned modulus);
        int unsigned nxt_v;
        nxt_v = value + 32'd1;
        if (nxt_v >= modulus) begin
            return 32'd0;
        end else begin
            return nxt_v;
        end
    endfunction

endpackage

// File: rtl/req_grant_arbiter_rr_pick.sv
// Rotating-priority picker: finds the first set bit of req_mask searching
// upward from ptr with wrap-around. Purely combinational.
module rr_pick #(
    parameter int unsigned N_REQ = 32'd4,
    parameter int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_mask,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [PTR_W-1:0] idx
);

    localparam int unsigned CW = PTR_W + 32'd1;

    logic [CW-1:0] cand_s;

    // Walk every candidate in rotating order and keep the first hit.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        cand_s = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            cand_s = {1'b0, ptr} + CW'(i);
            if (cand_s >= CW'(N_REQ)) begin
                cand_s = cand_s - CW'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!found && req_mask[cand_s[PTR_W-1:0]]) begin
                found = 1'b1;
                idx   = cand_s[PTR_W-1:0];
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/req_grant_arbiter.sv
// Round-robin arbiter with a per-owner hold limit. Grants are registered,
// released owners hand over without a bubble, and over-long owners are pre-empted.
module req_grant_arbiter
    import req_grant_pkg::*;
#(
    parameter int unsigned N_REQ    = DEF_N_REQ,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     timeout
);

    localparam int unsigned ID_W   = $clog2(N_REQ);
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 32'd1);

    arb_state_e        state_r, state_s;
    logic [N_REQ-1:0]  grant_r, grant_s;
    logic [ID_W-1:0]   owner_r, owner_s;
    logic [ID_W-1:0]   rr_ptr_r, rr_ptr_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
    logic              valid_r, valid_s;
    logic              timeout_r, timeout_s;

    logic              pick_found_s;
    logic [ID_W-1:0]   pick_idx_s;
    logic [N_REQ-1:0]  pick_grant_s;
    logic [ID_W-1:0]   pick_next_ptr_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (ID_W)
    ) u_rr_pick (
        .req_mask (req),
        .ptr      (rr_ptr_r),
        .found    (pick_found_s),
        .idx      (pick_idx_s)
    );

    // Decode the picked index into a one-hot grant and the pointer that follows it.
    always_comb begin
        pick_grant_s             = '0;
        pick_grant_s[pick_idx_s] = 1'b1;
        pick_next_ptr_s          = ID_W'(wrap_inc(32'(pick_idx_s), N_REQ));
    end

    // Next-state and next-output logic; the ex-owner sits just before rr_ptr so it is searched last.
    always_comb begin
        state_s    = state_r;
        grant_s    = '0;
        owner_s    = '0;
        rr_ptr_s   = rr_ptr_r;
        hold_cnt_s = hold_cnt_r;
        timeout_s  = 1'b0;
        valid_s    = 1'b0;

        case (state_r)
            IDLE, RELEASE: begin
                if (pick_found_s) begin
                    state_s    = GRANT;
                    grant_s    = pick_grant_s;
                    owner_s    = pick_idx_s;
                    rr_ptr_s   = pick_next_ptr_s;
                    hold_cnt_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                if (!req[owner_r]) begin
                    // A voluntary release wins over the hold limit, so no timeout here.
                    if (pick_found_s) begin
                        state_s    = GRANT;
                        grant_s    = pick_grant_s;
                        owner_s    = pick_idx_s;
                        rr_ptr_s   = pick_next_ptr_s;
                        hold_cnt_s = '0;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (hold_cnt_r < HOLD_LAST) begin
                    grant_s    = grant_r;
                    owner_s    = owner_r;
                    hold_cnt_s = hold_cnt_r + HOLD_W'(1);
                end else begin
                    state_s   = RELEASE;
                    timeout_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        valid_s = |grant_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            grant_r    <= '0;
            owner_r    <= '0;
            rr_ptr_r   <= '0;
            hold_cnt_r <= '0;
            valid_r    <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            grant_r    <= grant_s;
            owner_r    <= owner_s;
            rr_ptr_r   <= rr_ptr_s;
            hold_cnt_r <= hold_cnt_s;
            valid_r    <= valid_s;
            timeout_r  <= timeout_s;
        end
    end

    assign grant       = grant_r;
    assign grant_valid = valid_r;
    assign grant_id    = owner_r;
    assign timeout     = timeout_r;

endmodule

// File: tb/tb_req_grant_arbiter.sv
// Self-checking bench for req_grant_arbiter (N_REQ=4, MAX_HOLD=4): directed
// vector table, reset-during-grant sequence, and random traffic against a model.
module tb_req_grant_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    // Reference model: current owner (-1 = none), cycles granted so far,
    // last owner (next search starts just after it) and the timeout pulse.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = N - 1;
    bit m_to    = 1'b0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] id;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    req_grant_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    function automatic void model_pick(input logic [3:0] rq);
        m_owner = -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (m_owner < 0 && rq[c]) begin
                m_owner = c;
                m_last  = c;
                m_held  = 1;
            end
        end
    endfunction

    function automatic void model_edge(input logic r, input logic [3:0] rq);
        if (r) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = N - 1;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner >= 0 && rq[m_owner]) begin
                if (m_held < MH) begin
                    m_held++;
                end else begin
                    m_owner = -1;
                    m_to    = 1'b1;
                end
            end else begin
                model_pick(rq);
            end
        end
    endfunction

    function automatic logic [7:0] model_out();
        logic [3:0] g;
        logic [1:0] id;
        g  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        return {g, id, |g, m_to};
    endfunction

    task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: {grant,id,valid,timeout} got %b required %b", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq);
        rst = r;
        req = rq;
        @(posedge clk);
        model_edge(r, rq);
        #1;
        compare("model", {grant, grant_id, grant_valid, timeout}, model_out());
    endtask

    task automatic step_exp(input string name, input logic r, input logic [3:0] rq,
                            input logic [3:0] g, input logic [1:0] id, input logic to);
        step(r, rq);
        compare(name, {grant, grant_id, grant_valid, timeout}, {g, id, |g, to});
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] g,
                                input logic [1:0] id, input logic to);
        vec_t v;
        v.rst = r; v.req = rq; v.grant = g; v.id = id; v.to = to;
        return v;
    endfunction

    a_onehot: assert property (@(posedge clk) $onehot0(grant))
        else begin fails++; $display("FAIL onehot0 grant=%b", grant); end

    a_to_novalid: assert property (@(posedge clk) disable iff (rst) timeout |-> !grant_valid)
        else begin fails++; $display("FAIL timeout_with_grant grant=%b", grant); end

    a_idle_grant: assert property (@(posedge clk) disable iff (rst)
                                   (!grant_valid && (req != 4'b0000)) |=> grant_valid)
        else begin fails++; $display("FAIL idle_no_grant grant_valid=%b", grant_valid); end

    for (genvar gi = 0; gi < N; gi++) begin : g_rose
        a_rose: assert property (@(posedge clk) disable iff (rst) $rose(grant[gi]) |-> $past(req[gi]))
            else begin fails++; $display("FAIL rose_without_req bit=%0d", gi); end
    end

    initial begin
        logic [3:0] rq_v;
        logic [3:0] flip;
        logic       r_v;

        rst = 1'b1;
        req = 4'b0000;

        // reset, first grant after reset, release handover without bubble
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0));
        vecs.push_back(mk(1'b1, 4'b0001, 4'b0000, 2'd0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0));
        // all requesting: hold limit, timeout pulse, rotation
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b1));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1'b0, 4'b1111, 4'b0010, 2'd1, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b1));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0100, 2'd2, 1'b0));
        // release coinciding with the hold limit
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1'b0, 4'b0101, 4'b0001, 2'd0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].req);
            compare($sformatf("vec%0d", i), {grant, grant_id, grant_valid, timeout},
                    {vecs[i].grant, vecs[i].id, |vecs[i].grant, vecs[i].to});
        end

        // reset asserted while requester 3 owns the grant
        step_exp("rst_pre",     1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step_exp("own3",        1'b0, 4'b1000, 4'b1000, 2'd3, 1'b0);
        step_exp("own3_hold",   1'b0, 4'b1000, 4'b1000, 2'd3, 1'b0);
        step_exp("rst_mid",     1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0);
        step_exp("post_rst",    1'b0, 4'b1001, 4'b0001, 2'd0, 1'b0);
        step_exp("post_rst_h",  1'b0, 4'b1001, 4'b0001, 2'd0, 1'b0);

        // random traffic against the model
        rq_v = 4'b0000;
        for (int c = 0; c < 800; c++) begin
            flip = 4'b0000;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) flip[b] = 1'b1;
            end
            rq_v = rq_v ^ flip;
            r_v  = ($urandom_range(0, 99) == 0);
            step(r_v, rq_v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
